// File: rtl/maquina_estados_mc_pkg.sv
// Shared definitions for the multicycle control unit: state and class encodings,
// opcodes, ALU operation codes and datapath mux-select codes.
package controle_pkg;

    localparam logic [3:0] ST_RESET    = 4'd0;
    localparam logic [3:0] ST_FETCH    = 4'd1;
    localparam logic [3:0] ST_DECODE   = 4'd2;
    localparam logic [3:0] ST_REG_READ = 4'd3;
    localparam logic [3:0] ST_EXEC     = 4'd4;
    localparam logic [3:0] ST_MEM_WAIT = 4'd5;
    localparam logic [3:0] ST_MEM_RD   = 4'd6;
    localparam logic [3:0] ST_MEM_WR   = 4'd7;
    localparam logic [3:0] ST_WB       = 4'd8;
    localparam logic [3:0] ST_JALR_WB  = 4'd9;
    localparam logic [3:0] ST_HALT     = 4'd10;
    localparam logic [3:0] ST_TRAP     = 4'd11;

    typedef enum logic [3:0] {
        EST_RESET    = ST_RESET,
        EST_FETCH    = ST_FETCH,
        EST_DECODE   = ST_DECODE,
        EST_REG_READ = ST_REG_READ,
        EST_EXEC     = ST_EXEC,
        EST_MEM_WAIT = ST_MEM_WAIT,
        EST_MEM_RD   = ST_MEM_RD,
        EST_MEM_WR   = ST_MEM_WR,
        EST_WB       = ST_WB,
        EST_JALR_WB  = ST_JALR_WB,
        EST_HALT     = ST_HALT,
        EST_TRAP     = ST_TRAP
    } estado_t;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_ADDI = 7'b0010011;
    localparam logic [6:0] OPC_LD   = 7'b0000011;
    localparam logic [6:0] OPC_SD   = 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_SYS  = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;

    localparam logic [1:0] MA_PC     = 2'b00;
    localparam logic [1:0] MA_REGA   = 2'b01;
    localparam logic [1:0] MA_PCANT  = 2'b10;
    localparam logic [1:0] MA_ZERO   = 2'b11;
    localparam logic [1:0] MB_REGB   = 2'b00;
    localparam logic [1:0] MB_4      = 2'b01;
    localparam logic [1:0] MB_IMM    = 2'b10;
    localparam logic [1:0] MB_IMM_SH = 2'b11;
    localparam logic [1:0] MD_ALUOUT = 2'b00;
    localparam logic [1:0] MD_MDR    = 2'b01;
    localparam logic [1:0] MD_PC     = 2'b10;
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;

    typedef enum logic [3:0] {
        CL_R, CL_ADDI, CL_LD, CL_SD, CL_BR, CL_LUI, CL_JAL, CL_JALR, CL_EBREAK, CL_ILEGAL
    } classe_t;

    // ALU operation an instruction class uses in EXEC (and keeps on the bus in WB)
    function automatic logic [2:0] op_classe(input classe_t c, input logic [2:0] f3,
                                             input logic [6:0] f7);
        logic [2:0] op;
        op = OP_PASS;
        case (c)
            CL_R: begin
                case (f3)
                    3'b111:  op = OP_AND;
                    3'b100:  op = OP_XOR;
                    default: op = (f7 == F7_ALT) ? OP_SUB : OP_ADD;
                endcase
            end
            CL_ADDI, CL_LUI, CL_LD, CL_SD, CL_JALR: op = OP_ADD;
            CL_BR:   op = OP_SUB;
            default: op = OP_PASS;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/maquina_estados_mc_if.sv
// Bundle between the control unit (master) and the datapath (slave).
interface maquina_estados_mc_if;
    logic [31:0] INSTRUCAO;
    logic        ZERO_ALU;
    logic        MENOR_ALU;
    logic [2:0]  operacao;
    logic [1:0]  SELETOR_MUX_A;
    logic [1:0]  SELETOR_MUX_B;
    logic [1:0]  SELECT_MUX_DATA;
    logic [1:0]  SELETOR_PC;
    logic        WRITE_PC;
    logic        LOAD_IR;
    logic        WR_BANCO_REG;
    logic        WR_ALU_OUT;
    logic        wrDataMem;
    logic        wrDataMemReg;
    logic        write_reg_A;
    logic        write_reg_B;
    logic        reset_wire;
    logic        HALT;
    logic        TRAP;
    logic [3:0]  estado;

    modport master (
        input  INSTRUCAO, ZERO_ALU, MENOR_ALU,
        output operacao, SELETOR_MUX_A, SELETOR_MUX_B, SELECT_MUX_DATA, SELETOR_PC,
               WRITE_PC, LOAD_IR, WR_BANCO_REG, WR_ALU_OUT, wrDataMem, wrDataMemReg,
               write_reg_A, write_reg_B, reset_wire, HALT, TRAP, estado
    );

    modport slave (
        output INSTRUCAO, ZERO_ALU, MENOR_ALU,
        input  operacao, SELETOR_MUX_A, SELETOR_MUX_B, SELECT_MUX_DATA, SELETOR_PC,
               WRITE_PC, LOAD_IR, WR_BANCO_REG, WR_ALU_OUT, wrDataMem, wrDataMemReg,
               write_reg_A, write_reg_B, reset_wire, HALT, TRAP, estado
    );
endinterface

// File: rtl/maquina_estados_mc_decodificador.sv
// Combinational instruction classifier; anything outside the supported subset is ILEGAL.
module decodificador_instr
    import controle_pkg::*;
#(
    parameter bit EN_JUMP = 1'b1
) (
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output classe_t    classe_o
);

    // map opcode/funct fields onto an instruction class
    always_comb begin
        classe_o = CL_ILEGAL;
        case (opcode_i)
            OPC_R: begin
                if ((funct7_i == F7_BASE && (funct3_i == 3'b000 || funct3_i == 3'b111 ||
                                             funct3_i == 3'b100)) ||
                    (funct7_i == F7_ALT && funct3_i == 3'b000))
                    classe_o = CL_R;
            end
            OPC_ADDI: if (funct3_i == 3'b000) classe_o = CL_ADDI;
            OPC_LD:   if (funct3_i == 3'b011) classe_o = CL_LD;
            OPC_SD:   if (funct3_i == 3'b111) classe_o = CL_SD;
            OPC_BR: begin
                if (funct3_i == 3'b000 || funct3_i == 3'b001 ||
                    funct3_i == 3'b100 || funct3_i == 3'b101)
                    classe_o = CL_BR;
            end
            OPC_LUI:  classe_o = CL_LUI;
            OPC_JAL:  if (EN_JUMP) classe_o = CL_JAL;
            OPC_JALR: if (EN_JUMP && funct3_i == 3'b000) classe_o = CL_JALR;
            OPC_SYS:  classe_o = CL_EBREAK;
            default:  classe_o = CL_ILEGAL;
        endcase
    end

endmodule

// File: rtl/maquina_estados_mc.sv
// Multicycle control unit: sequences fetch/decode/execute with a memory-latency
// wait counter, and parks in HALT (ebreak) or TRAP (illegal) until reset.
module maquina_estados_mc
    import controle_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1,
    parameter bit          EN_JUMP = 1'b1
) (
    input logic                 CLK,
    input logic                 RST_N,
    maquina_estados_mc_if.master ctrl
);

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    estado_t    state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    classe_t    classe;
    logic [2:0] f3;
    logic [2:0] alu_op;
    logic       taken;

    assign f3 = ctrl.INSTRUCAO[14:12];

    decodificador_instr #(.EN_JUMP(EN_JUMP)) u_dec (
        .opcode_i (ctrl.INSTRUCAO[6:0]),
        .funct3_i (f3),
        .funct7_i (ctrl.INSTRUCAO[31:25]),
        .classe_o (classe)
    );

    assign alu_op      = op_classe(classe, f3, ctrl.INSTRUCAO[31:25]);
    assign ctrl.estado = state_q;

    // branch condition from the flags of the current (EXEC) cycle
    always_comb begin
        case (f3)
            3'b000:  taken = ctrl.ZERO_ALU;
            3'b001:  taken = !ctrl.ZERO_ALU;
            3'b100:  taken = ctrl.MENOR_ALU;
            3'b101:  taken = !ctrl.MENOR_ALU;
            default: taken = 1'b0;
        endcase
    end

    // state and wait-counter registers; reset forces RESET at once
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= EST_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // next state; counter reloads whenever FETCH or MEM_WAIT is entered
    always_comb begin
        state_d = state_q;
        case (state_q)
            EST_RESET:    state_d = EST_FETCH;
            EST_FETCH:    if (cnt_q == 3'd0) state_d = EST_DECODE;
            EST_DECODE:   state_d = EST_REG_READ;
            EST_REG_READ: begin
                if (classe == CL_ILEGAL)      state_d = EST_TRAP;
                else if (classe == CL_EBREAK) state_d = EST_HALT;
                else                          state_d = EST_EXEC;
            end
            EST_EXEC: begin
                case (classe)
                    CL_LD:          state_d = EST_MEM_WAIT;
                    CL_SD:          state_d = EST_MEM_WR;
                    CL_JALR:        state_d = EST_JALR_WB;
                    CL_BR, CL_JAL:  state_d = EST_FETCH;
                    default:        state_d = EST_WB;
                endcase
            end
            EST_MEM_WAIT: if (cnt_q == 3'd0) state_d = EST_MEM_RD;
            EST_MEM_RD:   state_d = EST_WB;
            EST_MEM_WR, EST_WB, EST_JALR_WB: state_d = EST_FETCH;
            EST_HALT:     state_d = EST_HALT;
            EST_TRAP:     state_d = EST_TRAP;
            default:      state_d = EST_RESET;
        endcase

        cnt_d = (cnt_q == 3'd0) ? cnt_q : cnt_q - 3'd1;
        if (state_d != state_q && (state_d == EST_FETCH || state_d == EST_MEM_WAIT))
            cnt_d = LAT_M1;
    end

    // Moore-style control outputs; everything defaults low in every state
    always_comb begin
        ctrl.operacao        = OP_PASS;
        ctrl.SELETOR_MUX_A   = MA_PC;
        ctrl.SELETOR_MUX_B   = MB_REGB;
        ctrl.SELECT_MUX_DATA = MD_ALUOUT;
        ctrl.SELETOR_PC      = PC_ALU;
        ctrl.WRITE_PC        = 1'b0;
        ctrl.LOAD_IR         = 1'b0;
        ctrl.WR_BANCO_REG    = 1'b0;
        ctrl.WR_ALU_OUT      = 1'b0;
        ctrl.wrDataMem       = 1'b0;
        ctrl.wrDataMemReg    = 1'b0;
        ctrl.write_reg_A     = 1'b0;
        ctrl.write_reg_B     = 1'b0;
        ctrl.reset_wire      = 1'b0;
        ctrl.HALT            = 1'b0;
        ctrl.TRAP            = 1'b0;
        case (state_q)
            EST_RESET: ctrl.reset_wire = 1'b1;
            EST_DECODE: begin
                ctrl.LOAD_IR       = 1'b1;
                ctrl.WRITE_PC      = 1'b1;
                ctrl.SELETOR_MUX_A = MA_PC;
                ctrl.SELETOR_MUX_B = MB_4;
                ctrl.operacao      = OP_ADD;
                ctrl.SELETOR_PC    = PC_ALU;
            end
            EST_REG_READ: begin
                ctrl.write_reg_A   = 1'b1;
                ctrl.write_reg_B   = 1'b1;
                ctrl.WR_ALU_OUT    = 1'b1;
                ctrl.SELETOR_MUX_A = MA_PCANT;
                ctrl.SELETOR_MUX_B = MB_IMM_SH;
                ctrl.operacao      = OP_ADD;
            end
            EST_EXEC: begin
                ctrl.operacao = alu_op;
                case (classe)
                    CL_R: begin
                        ctrl.SELETOR_MUX_A = MA_REGA;
                        ctrl.SELETOR_MUX_B = MB_REGB;
                        ctrl.WR_ALU_OUT    = 1'b1;
                    end
                    CL_ADDI, CL_LD, CL_SD, CL_JALR: begin
                        ctrl.SELETOR_MUX_A = MA_REGA;
                        ctrl.SELETOR_MUX_B = MB_IMM;
                        ctrl.WR_ALU_OUT    = 1'b1;
                    end
                    CL_LUI: begin
                        ctrl.SELETOR_MUX_A = MA_ZERO;
                        ctrl.SELETOR_MUX_B = MB_IMM;
                        ctrl.WR_ALU_OUT    = 1'b1;
                    end
                    CL_BR: begin
                        ctrl.SELETOR_MUX_A = MA_REGA;
                        ctrl.SELETOR_MUX_B = MB_REGB;
                        if (taken) begin
                            ctrl.WRITE_PC   = 1'b1;
                            ctrl.SELETOR_PC = PC_ALUOUT;
                        end
                    end
                    CL_JAL: begin
                        ctrl.WR_BANCO_REG    = 1'b1;
                        ctrl.SELECT_MUX_DATA = MD_PC;
                        ctrl.WRITE_PC        = 1'b1;
                        ctrl.SELETOR_PC      = PC_ALUOUT;
                    end
                    default: ;
                endcase
            end
            EST_MEM_RD: ctrl.wrDataMemReg = 1'b1;
            EST_MEM_WR: ctrl.wrDataMem    = 1'b1;
            EST_WB: begin
                ctrl.WR_BANCO_REG    = 1'b1;
                ctrl.operacao        = alu_op;
                ctrl.SELECT_MUX_DATA = (classe == CL_LD) ? MD_MDR : MD_ALUOUT;
            end
            EST_JALR_WB: begin
                ctrl.WR_BANCO_REG    = 1'b1;
                ctrl.SELECT_MUX_DATA = MD_PC;
                ctrl.WRITE_PC        = 1'b1;
                ctrl.SELETOR_PC      = PC_ALUOUT;
            end
            EST_HALT: ctrl.HALT = 1'b1;
            EST_TRAP: ctrl.TRAP = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_maquina_estados_mc.sv
// Bench for maquina_estados_mc: two instances (MEM_LAT=1 with jumps, MEM_LAT=3
// without jumps) checked cycle by cycle against an instruction timeline model.
module tb_maquina_estados_mc;

    logic CLK = 1'b0;
    logic rst_a, rst_b;
    always #5 CLK = ~CLK;

    maquina_estados_mc_if ifa ();
    maquina_estados_mc_if ifb ();

    maquina_estados_mc #(.MEM_LAT(1), .EN_JUMP(1'b1)) dut_a (.CLK(CLK), .RST_N(rst_a), .ctrl(ifa));
    maquina_estados_mc #(.MEM_LAT(3), .EN_JUMP(1'b0)) dut_b (.CLK(CLK), .RST_N(rst_b), .ctrl(ifb));

    // enable bit positions inside the packed observation vector
    localparam logic [10:0] E_HALT = 11'b1 << 10, E_TRAP = 11'b1 << 9, E_RW = 11'b1 << 8,
                            E_RB = 11'b1 << 7, E_RA = 11'b1 << 6, E_MDR = 11'b1 << 5,
                            E_WM = 11'b1 << 4, E_AO = 11'b1 << 3, E_WB = 11'b1 << 2,
                            E_IR = 11'b1 << 1, E_PC = 11'b1;
    localparam logic [2:0] ADD = 3'd1, SUB = 3'd2, AND_ = 3'd3, XOR_ = 3'd4;
    localparam int unsigned K_ALU = 0, K_LD = 1, K_SD = 2, K_BR = 3, K_JAL = 4,
                            K_JALR = 5, K_BRK = 6, K_ILL = 7;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_LD    = 32'h0080B283;
    localparam logic [31:0] I_SD    = 32'h0050F423;
    localparam logic [31:0] I_BLT   = 32'h0020C463;
    localparam logic [31:0] I_JAL   = 32'h010000EF;
    localparam logic [31:0] I_JALR  = 32'h00808167;
    localparam logic [31:0] I_BRK   = 32'h00100073;
    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_LUI   = 32'h123452B7;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned fin;
    logic [21:0] q[$];
    logic [21:0] obs_a, obs_b;

    assign obs_a = {ifa.HALT, ifa.TRAP, ifa.reset_wire, ifa.write_reg_B, ifa.write_reg_A,
                    ifa.wrDataMemReg, ifa.wrDataMem, ifa.WR_ALU_OUT, ifa.WR_BANCO_REG,
                    ifa.LOAD_IR, ifa.WRITE_PC, ifa.SELETOR_PC, ifa.SELECT_MUX_DATA,
                    ifa.SELETOR_MUX_B, ifa.SELETOR_MUX_A, ifa.operacao};
    assign obs_b = {ifb.HALT, ifb.TRAP, ifb.reset_wire, ifb.write_reg_B, ifb.write_reg_A,
                    ifb.wrDataMemReg, ifb.wrDataMem, ifb.WR_ALU_OUT, ifb.WR_BANCO_REG,
                    ifb.LOAD_IR, ifb.WRITE_PC, ifb.SELETOR_PC, ifb.SELECT_MUX_DATA,
                    ifb.SELETOR_MUX_B, ifb.SELETOR_MUX_A, ifb.operacao};

    function automatic logic [21:0] mk(input logic [2:0] op, input logic [1:0] ma,
                                       input logic [1:0] mb, input logic [1:0] md,
                                       input logic [1:0] mpc, input logic [10:0] en);
        return {en, mpc, md, mb, ma, op};
    endfunction

    localparam logic [21:0] RSTV = {E_RW, 11'b0};

    function automatic logic [21:0] obs(input bit sel);
        return sel ? obs_b : obs_a;
    endfunction

    task automatic chk(input string tag, input logic [21:0] o, input logic [21:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic set_in(input bit sel, input logic [31:0] ins, input bit z, input bit m);
        if (sel) begin
            ifb.INSTRUCAO = ins; ifb.ZERO_ALU = z; ifb.MENOR_ALU = m;
        end else begin
            ifa.INSTRUCAO = ins; ifa.ZERO_ALU = z; ifa.MENOR_ALU = m;
        end
    endtask

    task automatic set_rst(input bit sel, input logic v);
        if (sel) rst_b = v;
        else     rst_a = v;
    endtask

    // expected per-cycle outputs of one instruction, starting at its first fetch cycle
    task automatic build(input logic [31:0] ins, input int unsigned lat, input bit ej,
                         input bit z, input bit m, output int unsigned f);
        logic [6:0] opc, f7;
        logic [2:0] f3, op;
        logic [1:0] ma, mb;
        int unsigned kind;
        bit taken;
        opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        kind = K_ILL; op = 3'd0; ma = 2'd0; mb = 2'd0; taken = 1'b0; f = 0;
        case (opc)
            7'h33: begin
                if (f7 == 7'h00 && f3 == 3'd0)      begin kind = K_ALU; op = ADD;  end
                else if (f7 == 7'h20 && f3 == 3'd0) begin kind = K_ALU; op = SUB;  end
                else if (f7 == 7'h00 && f3 == 3'd7) begin kind = K_ALU; op = AND_; end
                else if (f7 == 7'h00 && f3 == 3'd4) begin kind = K_ALU; op = XOR_; end
                ma = 2'd1; mb = 2'd0;
            end
            7'h13: if (f3 == 3'd0) begin kind = K_ALU; op = ADD; ma = 2'd1; mb = 2'd2; end
            7'h37: begin kind = K_ALU; op = ADD; ma = 2'd3; mb = 2'd2; end
            7'h03: if (f3 == 3'd3) kind = K_LD;
            7'h23: if (f3 == 3'd7) kind = K_SD;
            7'h63: begin
                case (f3)
                    3'd0: begin kind = K_BR; taken = z;  end
                    3'd1: begin kind = K_BR; taken = !z; end
                    3'd4: begin kind = K_BR; taken = m;  end
                    3'd5: begin kind = K_BR; taken = !m; end
                    default: ;
                endcase
            end
            7'h6F: if (ej) kind = K_JAL;
            7'h67: if (ej && f3 == 3'd0) kind = K_JALR;
            7'h73: kind = K_BRK;
            default: ;
        endcase

        repeat (lat) q.push_back('0);
        q.push_back(mk(ADD, 2'd0, 2'd1, 2'd0, 2'd0, E_IR | E_PC));
        q.push_back(mk(ADD, 2'd2, 2'd3, 2'd0, 2'd0, E_RA | E_RB | E_AO));
        case (kind)
            K_ALU: begin
                q.push_back(mk(op, ma, mb, 2'd0, 2'd0, E_AO));
                q.push_back(mk(op, 2'd0, 2'd0, 2'd0, 2'd0, E_WB));
            end
            K_LD: begin
                q.push_back(mk(ADD, 2'd1, 2'd2, 2'd0, 2'd0, E_AO));
                repeat (lat) q.push_back('0);
                q.push_back(mk(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, E_MDR));
                q.push_back(mk(ADD, 2'd0, 2'd0, 2'd1, 2'd0, E_WB));
            end
            K_SD: begin
                q.push_back(mk(ADD, 2'd1, 2'd2, 2'd0, 2'd0, E_AO));
                q.push_back(mk(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, E_WM));
            end
            K_BR: q.push_back(mk(SUB, 2'd1, 2'd0, 2'd0, taken ? 2'd1 : 2'd0,
                                 taken ? E_PC : 11'd0));
            K_JAL: q.push_back(mk(3'd0, 2'd0, 2'd0, 2'd2, 2'd1, E_WB | E_PC));
            K_JALR: begin
                q.push_back(mk(ADD, 2'd1, 2'd2, 2'd0, 2'd0, E_AO));
                q.push_back(mk(3'd0, 2'd0, 2'd0, 2'd2, 2'd1, E_WB | E_PC));
            end
            K_BRK: begin f = 1; repeat (10) q.push_back({E_HALT, 11'b0}); end
            default: begin f = 2; repeat (10) q.push_back({E_TRAP, 11'b0}); end
        endcase
    endtask

    // run one instruction from the start of its fetch; optionally pull reset at cycle abort_at
    task automatic do_instr(input bit sel, input logic [31:0] ins, input bit z, input bit m,
                            input string tag, input int abort_at, output int unsigned f);
        set_in(sel, ins, z, m);
        q.delete();
        build(ins, sel ? 3 : 1, !sel, z, m, f);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge CLK);
            chk($sformatf("%s c%0d", tag, i), obs(sel), q[i]);
            if (i == abort_at) begin
                set_rst(sel, 1'b0);
                #1;
                chk({tag, " async_rst"}, obs(sel), RSTV);
                return;
            end
            @(posedge CLK);
            #1;
        end
    endtask

    // hold reset, release just after an edge, check the single RESET cycle
    task automatic reset_dut(input bit sel, input string tag);
        set_rst(sel, 1'b0);
        #1;
        chk({tag, " hold"}, obs(sel), RSTV);
        @(posedge CLK);
        #1;
        set_rst(sel, 1'b1);
        @(negedge CLK);
        chk({tag, " reset_cycle"}, obs(sel), RSTV);
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] rnd_instr(input bit jumps);
        logic [31:0] w;
        logic [2:0] bf;
        int unsigned k;
        w = $urandom;
        k = $urandom_range(0, jumps ? 10 : 8);
        case ($urandom_range(0, 3))
            0: bf = 3'b000;
            1: bf = 3'b001;
            2: bf = 3'b100;
            default: bf = 3'b101;
        endcase
        case (k)
            0: w = {7'b0000000, w[24:15], 3'b000, w[11:7], 7'b0110011};
            1: w = {7'b0100000, w[24:15], 3'b000, w[11:7], 7'b0110011};
            2: w = {7'b0000000, w[24:15], 3'b111, w[11:7], 7'b0110011};
            3: w = {7'b0000000, w[24:15], 3'b100, w[11:7], 7'b0110011};
            4: w = {w[31:15], 3'b000, w[11:7], 7'b0010011};
            5: w = {w[31:15], 3'b011, w[11:7], 7'b0000011};
            6: w = {w[31:15], 3'b111, w[11:7], 7'b0100011};
            7: w = {w[31:15], bf, w[11:7], 7'b1100011};
            8: w = {w[31:7], 7'b0110111};
            9: w = {w[31:7], 7'b1101111};
            default: w = {w[31:15], 3'b000, w[11:7], 7'b1100111};
        endcase
        return w;
    endfunction

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0);
        set_in(1'b1, '0, 1'b0, 1'b0);
        #2;
        chk("a_por", obs_a, RSTV);
        chk("b_por", obs_b, RSTV);

        // MEM_LAT=1, jumps enabled
        reset_dut(1'b0, "a_rst");
        do_instr(1'b0, I_ADD, 1'b0, 1'b0, "add_lat1", -1, fin);
        do_instr(1'b0, I_BLT, 1'b0, 1'b1, "blt_taken", -1, fin);
        do_instr(1'b0, I_BLT, 1'b0, 1'b0, "blt_not_taken", -1, fin);
        do_instr(1'b0, I_SUB, 1'b1, 1'b0, "sub", -1, fin);
        do_instr(1'b0, I_LUI, 1'b0, 1'b0, "lui", -1, fin);
        do_instr(1'b0, I_JAL, 1'b0, 1'b0, "jal", -1, fin);
        do_instr(1'b0, I_JALR, 1'b0, 1'b0, "jalr", -1, fin);
        do_instr(1'b0, I_LD, 1'b0, 1'b0, "ld_lat1", -1, fin);
        do_instr(1'b0, I_SD, 1'b0, 1'b0, "sd_lat1", -1, fin);
        for (int n = 0; n < 30; n++)
            do_instr(1'b0, rnd_instr(1'b1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $sformatf("rnd_a%0d", n), -1, fin);
        do_instr(1'b0, I_BRK, 1'b0, 1'b0, "ebreak", -1, fin);

        // MEM_LAT=3, jumps disabled
        reset_dut(1'b1, "b_rst");
        do_instr(1'b1, I_LD, 1'b0, 1'b0, "ld_lat3", -1, fin);
        do_instr(1'b1, I_SD, 1'b0, 1'b0, "sd_lat3", -1, fin);
        do_instr(1'b1, I_ADD, 1'b0, 1'b0, "add_lat3", -1, fin);
        for (int n = 0; n < 10; n++)
            do_instr(1'b1, rnd_instr(1'b0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $sformatf("rnd_b%0d", n), -1, fin);
        do_instr(1'b1, I_SD, 1'b0, 1'b0, "sd_abort", 6, fin);
        reset_dut(1'b1, "b_rst_after_abort");
        do_instr(1'b1, I_ADD, 1'b0, 1'b0, "add_after_abort", -1, fin);
        do_instr(1'b1, I_JAL, 1'b0, 1'b0, "jal_disabled", -1, fin);
        reset_dut(1'b1, "b_rst_after_trap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
